// File: rtl/mul_pkg.sv
// Shared opcode encoding and operand-signedness decode for the pipelined multiplier.
package mul_pkg;

  localparam int unsigned MUL_OP_W = 2;

  localparam logic [MUL_OP_W-1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MULHU  = 2'b11;

  // Bit i set when opcode i treats that operand as unsigned.
  localparam logic [3:0] MUL_SRC1_UNS = 4'b1000;
  localparam logic [3:0] MUL_SRC2_UNS = 4'b1100;

endpackage

// File: rtl/mul_top.sv
// Combinational 32x32 signed multiplier core producing the full 64-bit product.
module mul_top (
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [63:0] res
);

  logic [63:0] src1_ext;
  logic [63:0] src2_ext;

  always_comb begin
    src1_ext = {{32{src1[31]}}, src1};
    src2_ext = {{32{src2[31]}}, src2};
    res      = src1_ext * src2_ext;
  end

endmodule

// File: rtl/mul_pipe_wrap.sv
// Two-stage elastic valid/ready wrapper around mul_top; the high word is corrected
// for unsigned operand interpretation before it is registered into S2.
module mul_pipe_wrap
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_src1,
  input  logic [31:0]         in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_res,
  output logic [TAG_W-1:0]    out_tag
);

  logic                s1_valid_q;
  logic [MUL_OP_W-1:0] s1_op_q;
  logic [31:0]         s1_src1_q;
  logic [31:0]         s1_src2_q;
  logic [TAG_W-1:0]    s1_tag_q;

  logic                s2_valid_q;
  logic [31:0]         s2_res_q;
  logic [TAG_W-1:0]    s2_tag_q;

  logic        s2_adv;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  logic        src1_uns;
  logic        src2_uns;
  logic [63:0] prod;
  logic [31:0] hi_word;
  logic [31:0] s2_res_d;

  mul_top u_mul_top (
    .src1 (s1_src1_q),
    .src2 (s1_src2_q),
    .res  (prod)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = (!s1_valid_q || s2_adv) && !flush;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // Signed product plus 2^32 * (other operand) for each operand whose sign bit is
  // really a magnitude bit; only the high word needs the correction.
  always_comb begin
    src1_uns = MUL_SRC1_UNS[s1_op_q];
    src2_uns = MUL_SRC2_UNS[s1_op_q];
    hi_word  = prod[63:32]
             + ((src2_uns && s1_src2_q[31]) ? s1_src1_q : 32'd0)
             + ((src1_uns && s1_src1_q[31]) ? s1_src2_q : 32'd0);
    s2_res_d = (s1_op_q == MUL_OP_MUL) ? prod[31:0] : hi_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_src1_q  <= '0;
      s1_src2_q  <= '0;
      s1_tag_q   <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= in_op;
      s1_src1_q  <= in_src1;
      s1_src2_q  <= in_src2;
      s1_tag_q   <= in_tag;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s1_tag_q;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_res   = s2_res_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_mul_pipe_wrap.sv
// Randomized self-checking bench for mul_pipe_wrap against a queue-based reference model.
module tb_mul_pipe_wrap;

  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  mul_pipe_wrap #(
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   phase = 0;
  int   lit_idx = 0;

  localparam logic [31:0]      LIT_RES [4] = '{32'hFFFF_FFEB, 32'h4000_0000,
                                               32'hFFFF_FFFE, 32'hFFFF_FFFF};
  localparam logic [TAG_W-1:0] LIT_TAG [4] = '{5'd3, 5'd7, 5'd11, 5'd19};

  // Reference: extend each operand per its signedness to 64 bits and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = op[1] ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Single compare process: every negedge, outputs against the model.
  always @(negedge clk) begin
    logic exp_vis;
    logic m_ready;
    if (!resetn) begin
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_res", out_res, 32'd0);
      check("rst_out_tag", {27'd0, out_tag}, 32'd0);
      q.delete();
    end else begin
      exp_vis = (q.size() > 0) && (q[0].acc < edge_cnt);
      m_ready = !flush && ((q.size() < 2) || out_ready);
      check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_vis});
      if (exp_vis) begin
        check("out_res", out_res, q[0].res);
        check("out_tag", {27'd0, out_tag}, {27'd0, q[0].tag});
        if (phase == 1 && out_ready && lit_idx < 4) begin
          check("lit_res", out_res, LIT_RES[lit_idx]);
          check("lit_tag", {27'd0, out_tag}, {27'd0, LIT_TAG[lit_idx]});
          lit_idx <= lit_idx + 1;
        end
        if (out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && m_ready)
        q.push_back('{ref_mul(in_op, in_src1, in_src2), in_tag, edge_cnt + 1});
    end
  end

  task automatic rand_req();
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, $urandom()};
    in_op   = 2'($urandom_range(0, 3));
    in_src1 = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
    in_src2 = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom();
    in_tag  = TAG_W'($urandom());
  endtask

  // Entered and left at posedge+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 50) begin
        $display("FAIL issue_timeout: in_ready stuck low at %0t", $time);
        $fatal(1, "request never accepted");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(1);

    // Directed values with literal expectations.
    phase = 1;
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd3);
    idle(3);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd7);
    idle(3);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    idle(3);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19);
    idle(3);
    phase = 2;

    // Back-to-back stream.
    for (int i = 0; i < 20; i++) begin
      rand_req();
      issue(in_op, in_src1, in_src2, in_tag);
    end
    idle(3);

    // Backpressure with in_valid held, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_req();
    for (int i = 0; i < 9; i++) begin
      if (i == 5) out_ready = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) rand_req();
    end
    in_valid = 1'b0;
    idle(4);

    // Flush with both stages full and a request pending.
    out_ready = 1'b0;
    rand_req(); issue(in_op, in_src1, in_src2, in_tag);
    rand_req(); issue(in_op, in_src1, in_src2, in_tag);
    rand_req();
    in_valid = 1'b1;
    flush    = 1'b1;
    idle(1);
    flush     = 1'b0;
    out_ready = 1'b1;
    rand_req();
    issue(in_op, in_src1, in_src2, in_tag);
    idle(4);

    // Random traffic, backpressure and occasional flush.
    for (int i = 0; i < 150; i++) begin
      rand_req();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      idle(1);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(4);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      rand_req();
      in_valid = 1'b1;
      idle(1);
    end
    #2;
    resetn   = 1'b0;
    in_valid = 1'b0;
    idle(2);
    #2;
    resetn = 1'b1;
    idle(1);
    rand_req();
    issue(in_op, in_src1, in_src2, in_tag);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe_wrap.md
# mul_pipe_wrap

Two-stage elastic pipeline wrapper around the existing combinational Booth/Wallace core `mul_top`.
- Accepts operands with a valid/ready handshake and an opcode (MUL / MULH / MULHSU / MULHU).
- Registers the operands, drives the 32x32 signed core, corrects the high word for unsigned operand interpretation, and returns a 32-bit result with the request tag.
- Sits between the execute-stage issue logic and writeback; `mul_top` remains untouched inside it.

## Interface
Parameters:
- `TAG_W`, 5, width of the opaque request tag carried alongside the operation.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_op`  in  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (src1 signed × src2 unsigned, high), 11 MULHU (u×u high).
- `in_src1`  in  32  multiplicand.
- `in_src2`  in  32  multiplier.
- `in_tag`  in  TAG_W  request tag.
- `flush`  in  1  kill all in-flight requests.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `out_res`  out  32  result word.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Stage S1 holds `s1_valid`, op, src1, src2, tag. The S1 operands drive `mul_top` combinationally, giving the 64-bit signed product P.
- Stage S2 holds `s2_valid`, result, tag. On S1→S2 advance:
  - lo = P[31:0].
  - hi = P[63:32] + (src2 unsigned && src2[31] ? src1 : 0) + (src1 unsigned && src1[31] ? src2 : 0), mod 2^32.
  - src1 is unsigned only for MULHU. src2 is unsigned for MULHSU and MULHU.
  - Captured result = lo for MUL, otherwise hi.
- Handshake (skid-free elastic chain):
  - s2_adv = !s2_valid || out_ready.
  - in_ready = (!s1_valid || s2_adv) && !flush.
  - S1 loads on in_valid && in_ready. Otherwise it clears when it advances, and holds when it does not.
  - S2 loads from S1 when s1_valid && s2_adv. Otherwise it clears on an output handshake, and holds when stalled.
- Stalled outputs: `out_res` and `out_tag` stay stable while out_valid && !out_ready. Inputs are never re-sampled into a held stage.
- Flush: `s1_valid` and `s2_valid` are both 0 after the edge. No input is accepted that cycle, and any out_valid handshake in that cycle still completes.
- Reset (any time, including mid-operation): all valids 0, `out_res` 0, `out_tag` 0, stage data 0. `in_ready` = 1 after reset while flush = 0.

## Timing
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1 if unstalled (2 cycles).
- Throughput: 1 request per cycle with out_ready held high.
- Simultaneous accept into S1 and S1→S2 advance in the same cycle is required for full throughput.
- Backpressure: with out_ready = 0, at most 2 requests are held. in_ready drops once S1 and S2 are both full.
- Critical path: `mul_top` plus the 32-bit three-input high-word add, S1→S2. Nothing combinational runs from inputs to outputs except `in_ready`, which depends on `out_ready` and `flush`.

## Structure
- Shared package `mul_pkg`:
  - `MUL_OP_W` = 2.
  - Opcode constants `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU`.
  - Helper constants for the unsigned-src1 and unsigned-src2 decode.
- Sub-module: one instance of the existing `mul_top` (src1, src2 → res). No new sub-module; the correction adder is inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), out_ready = 1 -> out_res 0xFFFFFFEB two cycles after accept, with the tag echoed.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Back-to-back stream of 20 random requests (all ops), out_ready = 1 -> one result per cycle, in order, matching a 64-bit reference model with per-op sign extension.
- Backpressure: out_ready = 0 for 5 cycles with in_valid held -> in_ready falls after 2 accepts, and out_res/out_tag stay constant. Raising out_ready drains in order with no loss or duplication.
- Flush with both stages full and in_valid = 1 -> out_valid = 0 next cycle, the input is not accepted, and the following request returns normally after 2 cycles.
- Assert resetn low mid-stream (asynchronously, between edges) -> out_valid, out_res, out_tag go to 0 immediately. After release, in_ready = 1 and the first new request completes in 2 cycles.
